dmem_peripheral_responder: RTL and testbench

- Memory-mapped peripheral responder on the CPU data-memory port, at the opposite end of the same interface that the processor core drives.
- Decodes a 16-byte window at the top of the address space.
- Holds four 8-bit PWM duty registers that drive the LED and RGB outputs, plus free-running microsecond and millisecond counters.
- Sits beside the data memory; the top level muxes dmem_data_out between the two using the hit output.

---
 rtl/mmio_pkg.sv | 44 ++++
 rtl/pwm_channel.sv | 24 ++
 rtl/dmem_peripheral_responder.sv | 137 +++++++++++++
 tb/tb_dmem_peripheral_responder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the data-memory port: funct3 encodings,
// peripheral register offsets and load-lane helpers.
package mmio_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] OFF_DUTY = 4'h0;
    localparam logic [3:0] OFF_US   = 4'h4;
    localparam logic [3:0] OFF_MS   = 4'h8;

    localparam logic [31:0] DEF_BASE_ADDR = 32'hFFFF_FFF0;

    function automatic logic misaligned(input logic [2:0] f3,
                                        input logic [1:0] a);
        logic m;
        m = 1'b0;
        case (f3)
            F3_H, F3_HU: m = a[0];
            F3_W:        m = (a != 2'b00);
            default:     m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        case (f3)
            F3_B:    r = {{24{w[7]}}, w[7:0]};
            F3_H:    r = {{16{w[15]}}, w[15:0]};
            F3_W:    r = w;
            F3_BU:   r = {24'b0, w[7:0]};
            F3_HU:   r = {16'b0, w[15:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: registered high while the shared counter is below duty.
module pwm_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] duty_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    output logic                pwm_out_o
);

    logic pwm_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= (pwm_cnt_i < duty_i);
        end
    end

    assign pwm_out_o = pwm_q;

endmodule

// File: rtl/dmem_peripheral_responder.sv
// MMIO responder in a 16-byte window: four PWM duty bytes plus
// free-running microsecond / millisecond counters.
module dmem_peripheral_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          CLK_FREQ_HZ = 12_000_000,
    parameter int          PWM_BITS    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  funct3,
    input  logic        dmem_wren,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_data_in,
    output logic [31:0] dmem_data_out,
    output logic        hit,
    output logic        led,
    output logic        red,
    output logic        green,
    output logic        blue
);

    localparam int US_DIV = CLK_FREQ_HZ / 1_000_000;
    localparam int PRE_W  = (US_DIV > 2) ? $clog2(US_DIV) : 1;
    localparam logic [PRE_W-1:0] US_LAST = PRE_W'(US_DIV - 1);
    localparam logic [9:0]       MS_LAST = 10'd999;

    logic [31:0]         duty_q, duty_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PRE_W-1:0]    us_pre_q, us_pre_d;
    logic [31:0]         us_cnt_q, us_cnt_d;
    logic [9:0]          ms_pre_q, ms_pre_d;
    logic [31:0]         ms_cnt_q, ms_cnt_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                hit_q, hit_d;

    logic        in_win, us_tick, ms_tick, wr_ok;
    logic [1:0]  lane;
    logic [3:0]  wmask;
    logic [31:0] wdata, rword, rshift;

    assign in_win = (dmem_address[31:4] == BASE_ADDR[31:4]);
    assign lane   = dmem_address[1:0];

    always_comb begin
        us_tick   = (us_pre_q == US_LAST);
        ms_tick   = us_tick && (ms_pre_q == MS_LAST);
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        us_pre_d  = us_tick ? '0 : us_pre_q + PRE_W'(1);
        us_cnt_d  = us_cnt_q + {31'b0, us_tick};
        ms_pre_d  = ms_pre_q;
        if (us_tick) begin
            ms_pre_d = ms_tick ? '0 : ms_pre_q + 10'd1;
        end
        ms_cnt_d  = ms_cnt_q + {31'b0, ms_tick};
    end

    always_comb begin
        wr_ok = dmem_wren && in_win && !misaligned(funct3, lane)
                && (dmem_address[3:2] == OFF_DUTY[3:2]);
        wmask = 4'b0000;
        case (funct3)
            F3_B:    wmask = 4'b0001 << lane;
            F3_H:    wmask = lane[1] ? 4'b1100 : 4'b0011;
            F3_W:    wmask = 4'b1111;
            default: wmask = 4'b0000;
        endcase
        wdata  = dmem_data_in << {lane, 3'b000};
        duty_d = duty_q;
        for (int i = 0; i < 4; i++) begin
            if (wr_ok && wmask[i]) begin
                duty_d[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    // Read path samples the registers before this edge's write lands.
    always_comb begin
        rword = '0;
        case (dmem_address[3:2])
            OFF_DUTY[3:2]: rword = duty_q;
            OFF_US[3:2]:   rword = us_cnt_q;
            OFF_MS[3:2]:   rword = ms_cnt_q;
            default:       rword = '0;
        endcase
        rshift  = rword >> {lane, 3'b000};
        rdata_d = '0;
        if (in_win && !misaligned(funct3, lane)) begin
            rdata_d = load_extend(funct3, rshift);
        end
        hit_d = in_win;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            duty_q    <= '0;
            pwm_cnt_q <= '0;
            us_pre_q  <= '0;
            us_cnt_q  <= '0;
            ms_pre_q  <= '0;
            ms_cnt_q  <= '0;
            rdata_q   <= '0;
            hit_q     <= 1'b0;
        end else begin
            duty_q    <= duty_d;
            pwm_cnt_q <= pwm_cnt_d;
            us_pre_q  <= us_pre_d;
            us_cnt_q  <= us_cnt_d;
            ms_pre_q  <= ms_pre_d;
            ms_cnt_q  <= ms_cnt_d;
            rdata_q   <= rdata_d;
            hit_q     <= hit_d;
        end
    end

    assign dmem_data_out = rdata_q;
    assign hit           = hit_q;

    logic [3:0] pwm_out;

    for (genvar g = 0; g < 4; g++) begin : g_pwm
        pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm (
            .clk       (clk),
            .reset     (reset),
            .duty_i    (duty_q[8*g +: PWM_BITS]),
            .pwm_cnt_i (pwm_cnt_q),
            .pwm_out_o (pwm_out[g])
        );
    end

    assign led   = pwm_out[0];
    assign red   = pwm_out[1];
    assign green = pwm_out[2];
    assign blue  = pwm_out[3];

endmodule

// File: tb/tb_dmem_peripheral_responder.sv
// Scoreboard bench for dmem_peripheral_responder: directed loads/stores,
// PWM duty counts, timer boundaries and reset behaviour.
module tb_dmem_peripheral_responder;

    localparam logic [2:0] W  = 3'b010;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] B  = 3'b000;
    localparam logic [2:0] BU = 3'b100;
    localparam logic [2:0] HU = 3'b101;

    logic        clk;
    logic        reset;
    logic [2:0]  funct3;
    logic        dmem_wren;
    logic [31:0] dmem_address;
    logic [31:0] dmem_data_in;
    logic [31:0] dmem_data_out;
    logic        hit;
    logic        led, red, green, blue;

    dmem_peripheral_responder dut (
        .clk           (clk),
        .reset         (reset),
        .funct3        (funct3),
        .dmem_wren     (dmem_wren),
        .dmem_address  (dmem_address),
        .dmem_data_in  (dmem_data_in),
        .dmem_data_out (dmem_data_out),
        .hit           (hit),
        .led           (led),
        .red           (red),
        .green         (green),
        .blue          (blue)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [32:0] exp_q[$];
    string       name_q[$];
    logic        issue = 1'b0;
    logic        capt = 1'b0;

    always @(posedge clk) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
        capt <= issue;
    end

    task automatic chk(input string n, input logic [32:0] act,
                       input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (capt) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd: got %h expected none",
                         {hit, dmem_data_out});
            end else begin
                chk(name_q.pop_front(), {hit, dmem_data_out},
                    exp_q.pop_front());
            end
        end
    end

    task automatic rd(input logic [31:0] a, input logic [2:0] f,
                      input logic h, input logic [31:0] d,
                      input string n);
        dmem_address = a;
        funct3       = f;
        dmem_wren    = 1'b0;
        issue        = 1'b1;
        exp_q.push_back({h, d});
        name_q.push_back(n);
        @(negedge clk);
        issue = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] f,
                      input logic [31:0] d);
        dmem_address = a;
        funct3       = f;
        dmem_data_in = d;
        dmem_wren    = 1'b1;
        @(negedge clk);
        dmem_wren = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int n_led, n_red, n_green, n_blue;
    logic [31:0] e;

    initial begin
        reset        = 1'b0;
        funct3       = W;
        dmem_wren    = 1'b0;
        dmem_address = '0;
        dmem_data_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        chk("rst_bus", {hit, dmem_data_out}, 33'h0);
        chk("rst_pwm", {29'b0, led, red, green, blue}, 33'h0);

        wait_cyc(11);
        rd(32'hFFFF_FFF4, W, 1'b1, 32'd0, "us_at_11");
        rd(32'hFFFF_FFF4, W, 1'b1, 32'd1, "us_at_12");

        wr(32'hFFFF_FFF0, W, 32'h80FF_0040);
        rd(32'hFFFF_FFF0, W, 1'b1, 32'h80FF_0040, "lw_duty");
        repeat (2) @(negedge clk);
        n_led = 0; n_red = 0; n_green = 0; n_blue = 0;
        for (int i = 0; i < 256; i++) begin
            n_led   += int'(led);
            n_red   += int'(red);
            n_green += int'(green);
            n_blue  += int'(blue);
            @(negedge clk);
        end
        chk("pwm_led",   33'(n_led),   33'd64);
        chk("pwm_red",   33'(n_red),   33'd0);
        chk("pwm_green", 33'(n_green), 33'd255);
        chk("pwm_blue",  33'(n_blue),  33'd128);

        wr(32'hFFFF_FFF0, W, 32'h0);
        wr(32'hFFFF_FFF2, B, 32'h12);
        rd(32'hFFFF_FFF0, W, 1'b1, 32'h0012_0000, "sb_lane2");
        wr(32'hFFFF_FFF3, B, 32'h80);
        rd(32'hFFFF_FFF3, B,  1'b1, 32'hFFFF_FF80, "lb_sext");
        rd(32'hFFFF_FFF3, BU, 1'b1, 32'h0000_0080, "lbu_zext");
        rd(32'hFFFF_FFF2, H,  1'b1, 32'hFFFF_8012, "lh_sext");
        rd(32'hFFFF_FFF2, HU, 1'b1, 32'h0000_8012, "lhu_zext");

        wr(32'hFFFF_FFF1, W, 32'hDEAD_BEEF);
        wr(32'hFFFF_FFF3, H, 32'h0000_BEEF);
        wr(32'hFFFF_FFF0, 3'b011, 32'hFFFF_FFFF);
        rd(32'hFFFF_FFF0, W, 1'b1, 32'h8012_0000, "misal_wr");
        rd(32'hFFFF_FFF2, W, 1'b1, 32'h0, "misal_lw");
        rd(32'hFFFF_FFF1, H, 1'b1, 32'h0, "misal_lh");
        wr(32'hFFFF_FFF0, H, 32'h0000_3456);
        rd(32'hFFFF_FFF0, W, 1'b1, 32'h8012_3456, "sh_lo");

        wr(32'hFFFF_FFF4, W, 32'h0);
        e = 32'(cyc / 12);
        rd(32'hFFFF_FFF4, W, 1'b1, e, "us_ro");
        wr(32'hFFFF_FFFC, W, 32'h1234_5678);
        rd(32'hFFFF_FFFC, W, 1'b1, 32'h0, "reserved");

        dmem_address = 32'hFFFF_FFF0;
        dmem_data_in = 32'h5555_5555;
        funct3       = W;
        dmem_wren    = 1'b1;
        issue        = 1'b1;
        exp_q.push_back({1'b1, 32'h8012_3456});
        name_q.push_back("rd_before_wr");
        @(negedge clk);
        dmem_wren = 1'b0;
        issue     = 1'b0;
        rd(32'hFFFF_FFF0, W, 1'b1, 32'h5555_5555, "rd_after_wr");

        wait_cyc(11999);
        rd(32'hFFFF_FFF8, W, 1'b1, 32'd0, "ms_at_11999");
        rd(32'hFFFF_FFF8, W, 1'b1, 32'd1, "ms_at_12000");
        rd(32'hFFFF_FFF4, W, 1'b1, 32'd1000, "us_at_12001");

        wait_cyc(12012);
        force dut.us_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.us_cnt_q;
        rd(32'hFFFF_FFF4, W, 1'b1, 32'hFFFF_FFFF, "us_preload");
        wait_cyc(12023);
        rd(32'hFFFF_FFF4, W, 1'b1, 32'hFFFF_FFFF, "us_pre_wrap");
        rd(32'hFFFF_FFF4, W, 1'b1, 32'h0, "us_wrapped");

        wr(32'hFFFF_FFF0, W, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        reset        = 1'b0;
        dmem_address = 32'hFFFF_FFF0;
        dmem_data_in = 32'h1122_3344;
        funct3       = W;
        dmem_wren    = 1'b1;
        @(negedge clk);
        reset     = 1'b1;
        dmem_wren = 1'b0;
        chk("midrst_bus", {hit, dmem_data_out}, 33'h0);
        chk("midrst_pwm", {29'b0, led, red, green, blue}, 33'h0);
        rd(32'hFFFF_FFF0, W, 1'b1, 32'h0, "midrst_duty");
        rd(32'h0000_2000, W, 1'b0, 32'h0, "out_of_window");

        repeat (3) @(negedge clk);
        chk("drain", 33'(exp_q.size()), 33'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
